// File: rtl/seg_led_pkg.sv
// rtl/seg_led_pkg.sv - shared 7-segment code table, blank constant and count-mode type
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package seg_led_pkg;

    typedef enum logic {
        MODE_EQUAL = 1'b0,
        MODE_HEX   = 1'b1
    } count_mode_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

    localparam logic [7:0] SEG_CODE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble-to-segment decode with decimal point and blank control
module seg_decode
    import seg_led_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp_on,
    output logic [7:0] seg
);

    // Blanking overrides everything, including the decimal point.
    always_comb begin
        seg = SEG_CODE[nibble];
        if (dp_on) begin
            seg[DP_BIT] = 1'b0;
        end
        if (blank) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_led_scan_counter.sv
// rtl/seg_led_scan_counter.sv - tick-driven display value counter with multiplexed digit scan
// Optional leading-zero blanking in hex mode is enabled by defining SEG_LZ_BLANK_EN.
module seg_led_scan_counter
    import seg_led_pkg::*;
#(
    parameter int NUM_DIG  = 6,
    parameter int MAX_NUM  = 25_000_000,
    parameter int SCAN_NUM = 50_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 mode,
    input  logic                 pause,
    input  logic                 load,
    input  logic [4*NUM_DIG-1:0] load_val,
    output logic [NUM_DIG-1:0]   seg_sel,
    output logic [7:0]           seg_led
);

    localparam int VAL_W  = 4 * NUM_DIG;
    localparam int TICK_W = $clog2(MAX_NUM);
    localparam int SCAN_W = (SCAN_NUM > 1) ? $clog2(SCAN_NUM) : 1;
    localparam int IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_NUM - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_NUM - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIG - 1);

    count_mode_e       cur_mode;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [VAL_W-1:0]  val;
    logic [VAL_W-1:0]  val_next_tick;
    logic [3:0]        low_inc;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_wrap;
    logic [IDX_W-1:0]  dig_idx;

    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              cur_dp;
    logic [7:0]        dec_seg;

    assign cur_mode = count_mode_e'(mode);
    assign tick     = !pause && (tick_cnt == TICK_LAST);
    assign low_inc  = val[3:0] + 4'd1;

    // Mode is sampled only when a tick happens, so switching mode never alters val by itself.
    always_comb begin
        val_next_tick = val + VAL_W'(1);
        if (cur_mode == MODE_EQUAL) begin
            val_next_tick = {NUM_DIG{low_inc}};
        end
    end

    // Load wins over a coincident tick and is accepted while paused.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt <= '0;
            val      <= '0;
        end else if (load) begin
            tick_cnt <= '0;
            val      <= load_val;
        end else if (tick) begin
            tick_cnt <= '0;
            val      <= val_next_tick;
        end else if (!pause) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_idx == IDX_W'(i)) begin
                cur_nib = val[4*i +: 4];
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [IDX_W-1:0] top_idx;

    // Highest non-zero nibble; stays 0 for an all-zero value so digit 0 always shows.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (val[4*i +: 4] != 4'd0) begin
                top_idx = IDX_W'(i);
            end
        end
    end

    assign cur_blank = (cur_mode == MODE_HEX) && (dig_idx > top_idx);
`else
    assign cur_blank = 1'b0;
`endif

    assign cur_dp = pause && (dig_idx == '0);

    seg_decode u_seg_decode (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .dp_on  (cur_dp),
        .seg    (dec_seg)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seg_sel <= '1;
            seg_led <= SEG_OFF;
        end else begin
            seg_sel <= ~(NUM_DIG'(1) << dig_idx);
            seg_led <= dec_seg;
        end
    end

endmodule

// File: tb/tb_seg_led_scan_counter.sv
// tb/tb_seg_led_scan_counter.sv - directed self-checking bench for seg_led_scan_counter
module tb_seg_led_scan_counter;

    localparam int NUM_DIG  = 6;
    localparam int MAX_NUM  = 4;
    localparam int SCAN_NUM = 2;

`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    localparam logic [7:0] CODE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        sys_clk;
    logic        sys_rst;
    logic        mode;
    logic        pause;
    logic        load;
    logic [23:0] load_val;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;

    int n_tests;
    int n_fail;

    seg_led_scan_counter #(
        .NUM_DIG  (NUM_DIG),
        .MAX_NUM  (MAX_NUM),
        .SCAN_NUM (SCAN_NUM)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .mode     (mode),
        .pause    (pause),
        .load     (load),
        .load_val (load_val),
        .seg_sel  (seg_sel),
        .seg_led  (seg_led)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    function automatic int sel_idx(input logic [5:0] s);
        int cnt;
        int r;
        cnt = 0;
        r   = -1;
        for (int i = 0; i < 6; i++) begin
            if (s[i] === 1'b0) begin
                cnt++;
                r = i;
            end
        end
        if (cnt != 1) r = -1;
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [23:0] v, input int idx,
                                           input logic pm, input logic md);
        logic [7:0] e;
        int         msn;
        msn = 0;
        for (int i = 0; i < 6; i++) begin
            if (v[4*i +: 4] != 4'd0) msn = i;
        end
        e = CODE[v[4*idx +: 4]];
        if (pm && idx == 0) e[7] = 1'b0;
        if (LZ_EN && md && idx > msn) e = 8'hFF;
        return e;
    endfunction

    task automatic do_load(input logic [23:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge sys_clk);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] es;
        logic [7:0] el;
        sys_rst  = 1'b1;
        mode     = 1'b0;
        pause    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        #1;
        n_tests++;
        if (seg_sel !== 6'h3F || seg_led !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_initial: sel=%h led=%h required sel=3f led=ff", seg_sel, seg_led);
        end
        @(negedge sys_clk);
        n_tests++;
        if (seg_sel !== 6'h3F || seg_led !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_held: sel=%h led=%h required sel=3f led=ff", seg_sel, seg_led);
        end
        sys_rst = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge sys_clk);
            es = ~(6'd1 << ((j - 1) / 2));
            el = (j <= 4) ? 8'hC0 : ((j <= 8) ? 8'hF9 : 8'hA4);
            n_tests++;
            if (seg_sel !== es || seg_led !== el) begin
                n_fail++;
                $display("FAIL reset_release_scan cycle %0d: sel=%h led=%h required sel=%h led=%h",
                         j, seg_sel, seg_led, es, el);
            end
        end
    endtask

    task automatic test_mode0_count;
        logic [3:0]  k4;
        logic [23:0] ev;
        int          idx;
        mode = 1'b0;
        do_load(24'h000000);
        repeat (2) @(negedge sys_clk);
        for (int k = 1; k <= 16; k++) begin
            repeat (4) @(negedge sys_clk);
            k4  = 4'(k);
            ev  = {6{k4}};
            idx = sel_idx(seg_sel);
            n_tests++;
            if (idx < 0 || seg_led !== CODE[k4] || seg_led !== exp_seg(ev, idx, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL mode0_tick %0d: sel=%h led=%h required led=%h", k, seg_sel, seg_led, CODE[k4]);
            end
        end
    endtask

    task automatic check_window(input string name, input logic [23:0] ev, input int cycles);
        int         idx;
        logic [7:0] e;
        for (int c = 0; c < cycles; c++) begin
            @(negedge sys_clk);
            idx = sel_idx(seg_sel);
            e   = exp_seg(ev, (idx < 0) ? 0 : idx, pause, mode);
            n_tests++;
            if (idx < 0 || seg_led !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: sel=%h led=%h required val=%h led=%h",
                         name, c, seg_sel, seg_led, ev, e);
            end
        end
    endtask

    task automatic test_load_tick;
        mode = 1'b1;
        do_load(24'h000000);
        repeat (3) @(negedge sys_clk);
        do_load(24'h00000F);
        check_window("load_wins_over_tick", 24'h00000F, 4);
        check_window("hex_after_load", 24'h000010, 4);
        do_load(24'hFFFFFF);
        check_window("hex_all_f", 24'hFFFFFF, 4);
        check_window("hex_wrap", 24'h000000, 4);
    endtask

    task automatic test_pause;
        logic [5:0] seen;
        int         idx;
        mode  = 1'b1;
        pause = 1'b1;
        do_load(24'h123456);
        seen = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            idx   = sel_idx(seg_sel);
            seen |= ~seg_sel;
            n_tests++;
            if (idx < 0 || seg_led !== exp_seg(24'h123456, idx, 1'b1, 1'b1)) begin
                n_fail++;
                $display("FAIL pause_hold cycle %0d: sel=%h led=%h required val=123456", c, seg_sel, seg_led);
            end
        end
        n_tests++;
        if (seen !== 6'h3F) begin
            n_fail++;
            $display("FAIL pause_scan_continues: digits seen=%h required 3f", seen);
        end
        do_load(24'hABCDEF);
        check_window("load_during_pause", 24'hABCDEF, 4);
        pause = 1'b0;
        check_window("unpause_hold", 24'hABCDEF, 4);
        check_window("unpause_tick", 24'hABCDF0, 1);
    endtask

    task automatic test_mode_change;
        mode = 1'b1;
        do_load(24'h000005);
        mode = 1'b0;
        check_window("mode_change_no_effect", 24'h000005, 4);
        check_window("mode_change_next_tick", 24'h666666, 2);
    endtask

    task automatic test_blank;
        int idx;
        logic [7:0] e;
        mode  = 1'b1;
        pause = 1'b1;
        do_load(24'h000120);
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            idx = sel_idx(seg_sel);
            case (idx)
                0:       e = 8'h40;
                1:       e = 8'hA4;
                2:       e = 8'hF9;
                default: e = LZ_EN ? 8'hFF : 8'hC0;
            endcase
            n_tests++;
            if (idx < 0 || seg_led !== e) begin
                n_fail++;
                $display("FAIL leading_zero digit %0d: led=%h required %h", idx, seg_led, e);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [5:0] es;
        mode  = 1'b0;
        pause = 1'b0;
        do_load(24'h777777);
        repeat (2) @(negedge sys_clk);
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        n_tests++;
        if (seg_sel !== 6'h3F || seg_led !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset: sel=%h led=%h required sel=3f led=ff", seg_sel, seg_led);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge sys_clk);
            es = ~(6'd1 << ((j - 1) / 2));
            n_tests++;
            if (seg_sel !== es || seg_led !== 8'hC0) begin
                n_fail++;
                $display("FAIL reset_discards_val cycle %0d: sel=%h led=%h required sel=%h led=c0",
                         j, seg_sel, seg_led, es);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mode0_count();
        test_load_tick();
        test_pause();
        test_mode_change();
        test_blank();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
